fifo_buff_param: RTL and testbench

//  Parametrised synchronous FIFO; next generation of the team's 8x32 fifo_buff.

---
 rtl/fifo_buff_param.sv | 148 ++++++++++++++
 tb/tb_fifo_buff_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_buff_param.sv
// fifo_buff_param: parametrised single-clock FIFO with exact occupancy count,
// programmable almost-full/almost-empty thresholds and one-cycle
// overflow/underflow pulses.
// Optional macro FIFO_FWFT_EN selects first-word fall-through reads; when it
// is undefined the read port is registered with one cycle of latency.
module fifo_buff_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [DATA_W-1:0] datain,
    input  logic              rd,
    output logic [DATA_W-1:0] dataout,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_MARGIN);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              empty_s, full_s;
    logic              rd_acc_s, wr_acc_s;
`ifndef FIFO_FWFT_EN
    logic [DATA_W-1:0] dataout_q, dataout_d;
`endif

    // Status flags derived only from the registered occupancy.
    always_comb begin
        empty_s = (count_q == {CW{1'b0}});
        full_s  = (count_q == CNT_FULL);
    end

    // Accept decisions; a read frees a slot, so a full FIFO takes rd+wr together.
    always_comb begin
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        if (en) begin
            rd_acc_s = rd & ~empty_s;
            wr_acc_s = wr & (~full_s | rd);
        end else begin
            rd_acc_s = 1'b0;
            wr_acc_s = 1'b0;
        end
    end

    // Next-state for pointers, occupancy and the reject pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (wr_acc_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d     = count_q + CW'(wr_acc_s) - CW'(rd_acc_s);
        overflow_d  = en & wr & ~wr_acc_s;
        underflow_d = en & rd & ~rd_acc_s;
    end

`ifndef FIFO_FWFT_EN
    // Registered read port: capture the head word only when a read is accepted.
    always_comb begin
        dataout_d = dataout_q;
        if (rd_acc_s) begin
            dataout_d = mem_q[rd_ptr_q];
        end else begin
            dataout_d = dataout_q;
        end
    end
`endif

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifndef FIFO_FWFT_EN
    // Read data register, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataout_q <= {DATA_W{1'b0}};
        end else begin
            dataout_q <= dataout_d;
        end
    end
`endif

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

    // Output mapping.
    always_comb begin
        empty        = empty_s;
        full         = full_s;
        almost_empty = (count_q <= CNT_AE);
        almost_full  = (count_q >= CNT_AF);
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
`ifdef FIFO_FWFT_EN
        dataout      = empty_s ? {DATA_W{1'b0}} : mem_q[rd_ptr_q];
`else
        dataout      = dataout_q;
`endif
    end

endmodule

// File: tb/tb_fifo_buff_param.sv
// Directed self-checking bench for fifo_buff_param: a DEPTH=8 instance for
// the fill/drain/simultaneous/enable/reset cases and a DEPTH=5 instance for
// pointer wrap under bursty traffic against a queue scoreboard.
module tb_fifo_buff_param;

`ifdef FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=8 instance
    logic        rst, en, wr, rd;
    logic [31:0] din, dout;
    logic        empty, full, aempty, afull, ovf, udf;
    logic [3:0]  cnt;

    // DEPTH=5 instance
    logic        rst5, en5, wr5, rd5;
    logic [31:0] din5, dout5;
    logic        empty5, full5, aempty5, afull5, ovf5, udf5;
    logic [2:0]  cnt5;

    int total = 0;
    int bad   = 0;

    fifo_buff_param #(.DATA_W(32), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .datain(din), .rd(rd),
        .dataout(dout), .empty(empty), .full(full), .almost_empty(aempty),
        .almost_full(afull), .count(cnt), .overflow(ovf), .underflow(udf)
    );

    fifo_buff_param #(.DATA_W(32), .DEPTH(5), .AF_MARGIN(1), .AE_MARGIN(1)) u_dut5 (
        .clk(clk), .rst(rst5), .en(en5), .wr(wr5), .datain(din5), .rd(rd5),
        .dataout(dout5), .empty(empty5), .full(full5), .almost_empty(aempty5),
        .almost_full(afull5), .count(cnt5), .overflow(ovf5), .underflow(udf5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flags8(input string tag, input int c);
        chk({tag, "_count"}, 64'(cnt), 64'(c));
        chk({tag, "_empty"}, 64'(empty), 64'(c == 0));
        chk({tag, "_full"}, 64'(full), 64'(c == 8));
        chk({tag, "_aempty"}, 64'(aempty), 64'(c <= 1));
        chk({tag, "_afull"}, 64'(afull), 64'(c >= 7));
    endtask

    task automatic push8(input logic [31:0] d);
        wr  = 1'b1;
        din = d;
        cyc();
        wr  = 1'b0;
    endtask

    // popped: word a registered read returns; nxt: new head (0 if now empty)
    task automatic pop8(input string tag, input logic [31:0] popped, input logic [31:0] nxt);
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        chk(tag, 64'(dout), 64'(FWFT ? nxt : popped));
    endtask

    logic [31:0] sb[$];
    logic [31:0] popped5, exp_dout5;
    int          mc, nw, phase, cyc_n;
    logic        w5, r5, wa5, ra5;

    initial begin
        rst = 1'b1; en = 1'b0; wr = 1'b0; rd = 1'b0; din = 32'h0;
        rst5 = 1'b1; en5 = 1'b0; wr5 = 1'b0; rd5 = 1'b0; din5 = 32'h0;
        cyc();
        cyc();
        rst = 1'b0; rst5 = 1'b0; en = 1'b1;

        // reset state
        flags8("rst", 0);
        chk("rst_dout", 64'(dout), 64'h0);
        chk("rst_ovf", 64'(ovf), 64'h0);
        chk("rst_udf", 64'(udf), 64'h0);

        // fill to full, then one rejected write
        for (int i = 1; i <= 8; i++) begin
            push8(32'(i * 32'h11));
            flags8("t1_fill", i);
            chk("t1_fill_ovf", 64'(ovf), 64'h0);
        end
        wr = 1'b1; din = 32'h99;
        cyc();
        wr = 1'b0;
        chk("t1_ovf_pulse", 64'(ovf), 64'h1);
        flags8("t1_ovf", 8);
        cyc();
        chk("t1_ovf_clear", 64'(ovf), 64'h0);

        // drain, then one rejected read
        for (int i = 1; i <= 8; i++) begin
            pop8("t2_rd", 32'(i * 32'h11), (i < 8) ? 32'((i + 1) * 32'h11) : 32'h0);
            flags8("t2_drain", 8 - i);
        end
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        chk("t2_udf_pulse", 64'(udf), 64'h1);
        chk("t2_udf_dout", 64'(dout), FWFT ? 64'h0 : 64'h88);
        cyc();
        chk("t2_udf_clear", 64'(udf), 64'h0);

        // simultaneous rd+wr at count 3
        push8(32'hA1); push8(32'hA2); push8(32'hA3);
        rd = 1'b1; wr = 1'b1; din = 32'hA4;
        cyc();
        rd = 1'b0; wr = 1'b0;
        flags8("t3_mid", 3);
        chk("t3_mid_dout", 64'(dout), FWFT ? 64'hA2 : 64'hA1);
        pop8("t3_mid_rd", 32'hA2, 32'hA3);
        pop8("t3_mid_rd", 32'hA3, 32'hA4);
        pop8("t3_mid_rd", 32'hA4, 32'h0);

        // simultaneous rd+wr at full
        for (int i = 0; i < 8; i++) push8(32'hB0 + 32'(i));
        rd = 1'b1; wr = 1'b1; din = 32'hB8;
        cyc();
        rd = 1'b0; wr = 1'b0;
        flags8("t3_full", 8);
        chk("t3_full_ovf", 64'(ovf), 64'h0);
        chk("t3_full_udf", 64'(udf), 64'h0);
        chk("t3_full_dout", 64'(dout), FWFT ? 64'hB1 : 64'hB0);
        for (int i = 1; i <= 8; i++) begin
            pop8("t3_full_rd", 32'hB0 + 32'(i), (i < 8) ? 32'hB1 + 32'(i) : 32'h0);
        end

        // simultaneous rd+wr at empty
        rd = 1'b1; wr = 1'b1; din = 32'hC0;
        cyc();
        rd = 1'b0; wr = 1'b0;
        flags8("t3_empty", 1);
        chk("t3_empty_udf", 64'(udf), 64'h1);
        chk("t3_empty_ovf", 64'(ovf), 64'h0);
        chk("t3_empty_dout", 64'(dout), FWFT ? 64'hC0 : 64'hB8);

        // wrap and bursts on DEPTH=5
        en5 = 1'b1; mc = 0; nw = 0; exp_dout5 = 32'h0; cyc_n = 0;
        while (cyc_n < 600 && (nw < 23 || mc > 0)) begin
            phase = (cyc_n / 5) % 3;
            if (nw >= 23) begin
                w5 = 1'b0;
                r5 = 1'b1;
            end else if (phase == 0) begin
                w5 = ($urandom_range(0, 3) != 0);
                r5 = ($urandom_range(0, 3) == 0);
            end else if (phase == 1) begin
                w5 = ($urandom_range(0, 3) == 0);
                r5 = ($urandom_range(0, 3) != 0);
            end else begin
                w5 = ($urandom_range(0, 1) == 1);
                r5 = ($urandom_range(0, 1) == 1);
            end
            wr5 = w5; rd5 = r5; din5 = 32'hD000_0000 + 32'(nw);
            ra5 = r5 && (mc > 0);
            wa5 = w5 && ((mc < 5) || r5);
            if (ra5) begin
                popped5 = sb.pop_front();
                exp_dout5 = popped5;
            end
            if (wa5) sb.push_back(din5);
            mc = mc + int'(wa5) - int'(ra5);
            nw = nw + int'(wa5);
            cyc();
            chk("t4_count", 64'(cnt5), 64'(mc));
            chk("t4_empty", 64'(empty5), 64'(mc == 0));
            chk("t4_full", 64'(full5), 64'(mc == 5));
            chk("t4_aempty", 64'(aempty5), 64'(mc <= 1));
            chk("t4_afull", 64'(afull5), 64'(mc >= 4));
            chk("t4_ovf", 64'(ovf5), 64'(w5 && !wa5));
            chk("t4_udf", 64'(udf5), 64'(r5 && !ra5));
            chk("t4_dout", 64'(dout5), FWFT ? ((mc > 0) ? 64'(sb[0]) : 64'h0) : 64'(exp_dout5));
            cyc_n++;
        end
        wr5 = 1'b0; rd5 = 1'b0;
        chk("t4_done", 64'((nw == 23) && (mc == 0)), 64'h1);

        // enable low freezes everything
        push8(32'hC1); push8(32'hC2); push8(32'hC3); push8(32'hC4);
        flags8("t5_fill", 5);
        en = 1'b0; rd = 1'b1; wr = 1'b1; din = 32'hEE;
        for (int i = 0; i < 4; i++) begin
            cyc();
            flags8("t5_hold", 5);
            chk("t5_hold_ovf", 64'(ovf), 64'h0);
            chk("t5_hold_udf", 64'(udf), 64'h0);
            chk("t5_hold_dout", 64'(dout), FWFT ? 64'hC0 : 64'hB8);
        end
        // reset overrides en=0
        rst = 1'b1; rd = 1'b0; wr = 1'b0;
        cyc();
        rst = 1'b0;
        flags8("t5_rst", 0);
        chk("t5_rst_dout", 64'(dout), 64'h0);
        en = 1'b1;

        // write to empty: fall-through without rd, or held until rd
        push8(32'hA5);
        flags8("t6_wr", 1);
        chk("t6_wr_dout", 64'(dout), FWFT ? 64'hA5 : 64'h0);
        pop8("t6_rd", 32'hA5, 32'h0);
        flags8("t6_rd", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
